// File: rtl/position_mask_decoder.sv
// Rebuilds a DATA_LEN-bit mask from a stream of bit positions; the finished
// mask, its popcount and sticky duplicate/range flags leave on a valid/ready port.
module position_mask_decoder #(
  parameter int DATA_LEN  = 8,
  parameter int DEPTH_LEN = $clog2(DATA_LEN),
  parameter int CNT_LEN   = $clog2(DATA_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pos_valid,
  output logic                 pos_ready,
  input  logic [DEPTH_LEN-1:0] pos,
  input  logic                 pos_last,
  output logic                 mask_valid,
  input  logic                 mask_ready,
  output logic [DATA_LEN-1:0]  mask,
  output logic [CNT_LEN-1:0]   mask_count,
  output logic                 dup_err,
  output logic                 range_err
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [DEPTH_LEN:0] LP_LEN = (DEPTH_LEN + 1)'(DATA_LEN);

  state_t               r_state, w_state_nxt;
  logic [DATA_LEN-1:0]  r_acc;
  logic [CNT_LEN-1:0]   r_cnt;
  logic                 r_dup, r_rng;
  logic [DATA_LEN-1:0]  r_mask;
  logic [CNT_LEN-1:0]   r_mask_cnt;
  logic                 r_mask_dup, r_mask_rng;

  logic                 w_accept, w_in_range, w_hit;
  logic [DATA_LEN-1:0]  w_onehot, w_acc_nxt;
  logic [CNT_LEN-1:0]   w_cnt_nxt;
  logic                 w_dup_nxt, w_rng_nxt;

  assign pos_ready  = (r_state == ACCUM);
  assign mask_valid = (r_state == HOLD);
  assign mask       = r_mask;
  assign mask_count = r_mask_cnt;
  assign dup_err    = r_mask_dup;
  assign range_err  = r_mask_rng;

  // Decoding is gated by acceptance so an idle or X position never reaches state.
  always_comb begin
    w_accept   = pos_valid & pos_ready;
    w_in_range = ({1'b0, pos} < LP_LEN);
    w_onehot   = '0;
    if (w_accept && w_in_range)
      w_onehot = DATA_LEN'(1) << pos;
    w_hit      = |(r_acc & w_onehot);
    w_acc_nxt  = r_acc | w_onehot;
    w_cnt_nxt  = r_cnt;
    if (|w_onehot && !w_hit)
      w_cnt_nxt = r_cnt + CNT_LEN'(1);
    w_dup_nxt  = r_dup | w_hit;
    w_rng_nxt  = r_rng | (w_accept & ~w_in_range);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: if (w_accept && pos_last) w_state_nxt = HOLD;
      HOLD:  if (mask_ready)           w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  // Accumulator clears on the same edge that hands the finished word to the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_dup      <= 1'b0;
      r_rng      <= 1'b0;
      r_mask     <= '0;
      r_mask_cnt <= '0;
      r_mask_dup <= 1'b0;
      r_mask_rng <= 1'b0;
    end else if (w_accept) begin
      if (pos_last) begin
        r_mask     <= w_acc_nxt;
        r_mask_cnt <= w_cnt_nxt;
        r_mask_dup <= w_dup_nxt;
        r_mask_rng <= w_rng_nxt;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_dup      <= 1'b0;
        r_rng      <= 1'b0;
      end else begin
        r_acc      <= w_acc_nxt;
        r_cnt      <= w_cnt_nxt;
        r_dup      <= w_dup_nxt;
        r_rng      <= w_rng_nxt;
      end
    end
  end

endmodule

// File: tb/tb_position_mask_decoder.sv
// Scoreboard bench for position_mask_decoder: an 8-bit instance for the main
// function and a 6-bit instance for out-of-range positions.
module tb_position_mask_decoder;

  typedef struct {
    logic [7:0] m;
    logic [3:0] c;
    logic       d;
    logic       r;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] pos = '0;
  logic       pos_last = 1'b0;
  logic       mr = 1'b1;
  logic       pv8 = 1'b0, pv6 = 1'b0;
  logic       prdy8, prdy6, mv8, mv6;
  logic [7:0] mask8;
  logic [5:0] mask6;
  logic [3:0] cnt8;
  logic [2:0] cnt6;
  logic       dup8, dup6, rng8, rng6;

  int   errors = 0;
  int   checks = 0;
  exp_t q8[$];
  exp_t q6[$];

  always #5 clk = ~clk;

  position_mask_decoder #(.DATA_LEN(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .pos_valid(pv8), .pos_ready(prdy8), .pos(pos),
    .pos_last(pos_last), .mask_valid(mv8), .mask_ready(mr), .mask(mask8),
    .mask_count(cnt8), .dup_err(dup8), .range_err(rng8)
  );

  position_mask_decoder #(.DATA_LEN(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .pos_valid(pv6), .pos_ready(prdy6), .pos(pos),
    .pos_last(pos_last), .mask_valid(mv6), .mask_ready(mr), .mask(mask6),
    .mask_count(cnt6), .dup_err(dup6), .range_err(rng6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] m, input logic [3:0] c,
                      input logic d, input logic r);
    exp_t e;
    e.m = m; e.c = c; e.d = d; e.r = r;
    if (sel == 0) q8.push_back(e);
    else          q6.push_back(e);
  endtask

  // Holds one beat until accepted; returns 1 time unit after the accepting edge.
  task automatic beat(input int sel, input logic [2:0] p, input logic last);
    int n;
    n = 0;
    pos = p;
    pos_last = last;
    if (sel == 0) pv8 = 1'b1; else pv6 = 1'b1;
    forever begin
      @(negedge clk);
      if ((sel == 0) ? prdy8 : prdy6) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: pos_ready stuck low, pos %0d", p);
        break;
      end
    end
    @(posedge clk);
    #1;
    pv8 = 1'b0;
    pv6 = 1'b0;
  endtask

  // Monitor: every completed handshake is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mr && mv8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL mask8_unexpected: got mask %0d with empty scoreboard", mask8);
      end else begin
        e = q8.pop_front();
        chk("mask8", 32'(mask8), 32'(e.m));
        chk("count8", 32'(cnt8), 32'(e.c));
        chk("dup8", 32'(dup8), 32'(e.d));
        chk("range8", 32'(rng8), 32'(e.r));
      end
    end
    if (rst_n && mr && mv6) begin
      if (q6.size() == 0) begin
        checks++; errors++;
        $display("FAIL mask6_unexpected: got mask %0d with empty scoreboard", mask6);
      end else begin
        e = q6.pop_front();
        chk("mask6", 32'(mask6), 32'(e.m));
        chk("count6", 32'(cnt6), 32'(e.c));
        chk("dup6", 32'(dup6), 32'(e.d));
        chk("range6", 32'(rng6), 32'(e.r));
      end
    end
  end

  initial begin
    int first1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid8", 32'(mv8), 0);
    chk("rst_mask8", 32'(mask8), 0);
    chk("rst_count8", 32'(cnt8), 0);
    chk("rst_ready8", 32'(prdy8), 1);
    chk("rst_valid6", 32'(mv6), 0);
    chk("rst_ready6", 32'(prdy6), 1);
    @(posedge clk); #1;

    // Basic word: 0,2,3 -> 13
    push(0, 8'd13, 4'd3, 1'b0, 1'b0);
    beat(0, 3'd0, 1'b0);
    beat(0, 3'd2, 1'b0);
    beat(0, 3'd3, 1'b1);

    // Duplicate then sticky-clear check
    push(0, 8'd68, 4'd2, 1'b1, 1'b0);
    beat(0, 3'd2, 1'b0);
    beat(0, 3'd2, 1'b0);
    beat(0, 3'd6, 1'b1);
    push(0, 8'd2, 4'd1, 1'b0, 1'b0);
    beat(0, 3'd1, 1'b1);

    // Back-pressure: single beat held in HOLD for 5 cycles
    @(posedge clk); #1;
    mr = 1'b0;
    push(0, 8'd128, 4'd1, 1'b0, 1'b0);
    beat(0, 3'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_mask", 32'(mask8), 128);
      chk("hold_count", 32'(cnt8), 1);
      chk("hold_valid", 32'(mv8), 1);
      chk("hold_ready", 32'(prdy8), 0);
    end
    @(posedge clk); #1;
    mr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_ready", 32'(prdy8), 1);
    chk("post_hs_valid", 32'(mv8), 0);
    @(posedge clk); #1;

    // Reset mid-word discards bits 1 and 4
    beat(0, 3'd1, 1'b0);
    beat(0, 3'd4, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(0, 8'd32, 4'd1, 1'b0, 1'b0);
    beat(0, 3'd5, 1'b1);

    // Out-of-range position on the 6-bit instance
    push(1, 8'b0010_0001, 4'd2, 1'b0, 1'b1);
    beat(1, 3'd6, 1'b0);
    beat(1, 3'd0, 1'b0);
    beat(1, 3'd5, 1'b1);

    // Round trip through a lowest-set-bit priority encoder model
    for (int p = 0; p < 8; p++) begin
      push(0, 8'(1 << p), 4'd1, 1'b0, 1'b0);
      beat(0, 3'(p), 1'b1);
      @(negedge clk);
      chk("rt_valid", 32'(mv8), 1);
      first1 = -1;
      for (int b = 7; b >= 0; b--)
        if (mask8[b]) first1 = b;
      chk("rt_first1", 32'(first1), 32'(p));
    end

    // All bits in one word: count reaches DATA_LEN
    push(0, 8'd255, 4'd8, 1'b0, 1'b0);
    for (int p = 0; p < 8; p++)
      beat(0, 3'(p), (p == 7) ? 1'b1 : 1'b0);

    repeat (4) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 0);
    chk("q6_drained", 32'(q6.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
